// File: rtl/uart_tx_serializer_p_if.sv
// Load/serial handshake bundle for uart_tx_serializer_p.
// Parity signals exist only when UART_TX_SER_PARITY_EN is defined.
interface uart_tx_serializer_p_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] p_data;
   logic                  data_valid;
   logic                  load_ready;
   logic                  ser_en;
   logic                  ser_busy;
   logic                  ser_data;
   logic                  ser_done;
`ifdef UART_TX_SER_PARITY_EN
   logic                  par_typ;
   logic                  par_bit;
`endif

   // master = data source plus frame FSM, slave = serializer
   modport master (
      output p_data, data_valid, ser_en,
`ifdef UART_TX_SER_PARITY_EN
      output par_typ,
      input  par_bit,
`endif
      input  load_ready, ser_busy, ser_data, ser_done
   );

   modport slave (
      input  p_data, data_valid, ser_en,
`ifdef UART_TX_SER_PARITY_EN
      input  par_typ,
      output par_bit,
`endif
      output load_ready, ser_busy, ser_data, ser_done
   );
endinterface

// File: rtl/uart_tx_serializer_p.sv
// Parametrised UART TX serializer: loads a word on data_valid && load_ready, shifts one bit per ser_en.
// Optional parity generation is enabled by defining UART_TX_SER_PARITY_EN.
module uart_tx_serializer_p #(
   parameter int DATA_WIDTH = 8,
   parameter bit LSB_FIRST  = 1'b1,
   parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
   input logic                   clk,
   input logic                   rst,
   uart_tx_serializer_p_if.slave bus
);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

   state_t                state;
   logic [DATA_WIDTH-1:0] shreg;
   logic [DATA_WIDTH-1:0] shreg_next;
   logic [CNT_W-1:0]      bit_cnt;
   logic                  next_bit;

   // LSB_FIRST picks which end of the shift register feeds the line
   always_comb begin
      if (LSB_FIRST) begin
         next_bit   = shreg[0];
         shreg_next = {1'b0, shreg[DATA_WIDTH-1:1]};
      end else begin
         next_bit   = shreg[DATA_WIDTH-1];
         shreg_next = {shreg[DATA_WIDTH-2:0], 1'b0};
      end
   end

   // NOTE: every flop here, status outputs included, resets asynchronously so the
   // handshake reads idle the instant rst rises; all state updates are non-blocking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         shreg          <= '0;
         bit_cnt        <= '0;
         bus.ser_data   <= 1'b0;
         bus.ser_done   <= 1'b0;
         bus.load_ready <= 1'b1;
         bus.ser_busy   <= 1'b0;
`ifdef UART_TX_SER_PARITY_EN
         bus.par_bit    <= 1'b0;
`endif
      end else begin
         // NOTE: default-low here, overridden below on the last bit, gives a one-cycle pulse.
         bus.ser_done <= 1'b0;
         case (state)
            IDLE: begin
               // ser_en is deliberately ignored while idle, even in the load cycle
               if (bus.data_valid) begin
                  shreg          <= bus.p_data;
                  bit_cnt        <= '0;
                  state          <= SHIFT;
                  bus.load_ready <= 1'b0;
                  bus.ser_busy   <= 1'b1;
`ifdef UART_TX_SER_PARITY_EN
                  bus.par_bit    <= ^bus.p_data ^ bus.par_typ;
`endif
               end
            end
            SHIFT: begin
               if (bus.ser_en) begin
                  bus.ser_data <= next_bit;
                  shreg        <= shreg_next;
                  if (bit_cnt == LAST_IDX) begin
                     // back to idle together with the done pulse so a new word can load now
                     bus.ser_done   <= 1'b1;
                     bus.load_ready <= 1'b1;
                     bus.ser_busy   <= 1'b0;
                     state          <= IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state          <= IDLE;
               bus.load_ready <= 1'b1;
               bus.ser_busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule
